// File: rtl/indirect_normal_accum_pkg.sv
// Shared widths, upper-triangle index tables and FSM state type for the
// indirect normal-equation accumulator.
package RgbdVoConfigPk;

    localparam int ID_COE_BW   = 24;
    localparam int NORM_ACC_BW = 64;
    localparam int NORM_CNT_BW = 19;
    localparam int NUM_H_TERM  = 21;
    localparam int NUM_B_TERM  = 6;

    // Term index -> (row, col) of the 6x6 upper triangle, row-major.
    localparam int H_ROW [NUM_H_TERM] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 4, 4, 5};
    localparam int H_COL [NUM_H_TERM] = '{0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 2, 3, 4, 5, 3, 4, 5, 4, 5, 5};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_DRAIN1 = 3'd2,
        ST_DRAIN2 = 3'd3,
        ST_DONE   = 3'd4
    } accum_state_e;

endpackage

// File: rtl/indirect_normal_accum_pair_mac.sv
// Two-stage registered a*b + c*d at full precision, with a valid bit that a
// flush drops while it sits in the first stage.
module indirect_pair_mac #(
    parameter int A_BW   = 24,
    parameter int B_BW   = 24,
    parameter int C_BW   = 24,
    parameter int D_BW   = 24,
    parameter int OUT_BW = 49
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic signed [A_BW-1:0]   i_a,
    input  logic signed [B_BW-1:0]   i_b,
    input  logic signed [C_BW-1:0]   i_c,
    input  logic signed [D_BW-1:0]   i_d,
    output logic                     o_valid,
    output logic signed [OUT_BW-1:0] o_sum
);

    localparam int AB_BW = A_BW + B_BW;
    localparam int CD_BW = C_BW + D_BW;

    logic signed [AB_BW-1:0]  ab_q;
    logic signed [CD_BW-1:0]  cd_q;
    logic signed [OUT_BW-1:0] sum_q;
    logic                     s1_v_q;
    logic                     s2_v_q;

    // Stage 1 registers both products, stage 2 their sign-extended sum.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            ab_q   <= '0;
            cd_q   <= '0;
            sum_q  <= '0;
        end else begin
            s1_v_q <= i_valid;
            s2_v_q <= s1_v_q & ~i_flush;
            ab_q   <= AB_BW'(i_a) * AB_BW'(i_b);
            cd_q   <= CD_BW'(i_c) * CD_BW'(i_d);
            sum_q  <= OUT_BW'(ab_q) + OUT_BW'(cd_q);
        end
    end

    assign o_valid = s2_v_q;
    assign o_sum   = sum_q;

endmodule

// File: rtl/indirect_normal_accum.sv
// Accumulates the 6x6 normal matrix (upper triangle) and gradient vector of the
// indirect reprojection stream over one frame; results are held after a done pulse.
module indirect_normal_accum
    import RgbdVoConfigPk::*;
#(
    parameter int COE_BW = ID_COE_BW,
    parameter int DX_BW  = 11,
    parameter int DY_BW  = 10,
    parameter int ACC_BW = NORM_ACC_BW,
    parameter int CNT_BW = NORM_CNT_BW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_valid,
    input  logic signed [COE_BW-1:0] i_Ax [6],
    input  logic signed [COE_BW-1:0] i_Ay [6],
    input  logic signed [DX_BW-1:0]  i_diffs_x,
    input  logic signed [DY_BW-1:0]  i_diffs_y,
    input  logic                     i_frame_end,
    output logic                     o_busy,
    output logic                     o_done,
    output logic signed [ACC_BW-1:0] o_H [NUM_H_TERM],
    output logic signed [ACC_BW-1:0] o_b [NUM_B_TERM],
    output logic [CNT_BW-1:0]        o_cnt,
    output logic                     o_ovf
);

    localparam int NT    = NUM_H_TERM + NUM_B_TERM;
    localparam int MAC_W = 2 * COE_BW + 1;
    localparam int SUM_W = ((ACC_BW > MAC_W) ? ACC_BW : MAC_W) + 1;
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'({1'b0, {(ACC_BW-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

    // Returns {saturated, clamped sum}.
    function automatic logic [ACC_BW:0] sat_add(input logic signed [ACC_BW-1:0] acc,
                                                input logic signed [MAC_W-1:0]  inc);
        logic signed [SUM_W-1:0] s;
        s = SUM_W'(acc) + SUM_W'(inc);
        if (s > ACC_MAX) begin
            sat_add = {1'b1, ACC_MAX[ACC_BW-1:0]};
        end else if (s < ACC_MIN) begin
            sat_add = {1'b1, ACC_MIN[ACC_BW-1:0]};
        end else begin
            sat_add = {1'b0, s[ACC_BW-1:0]};
        end
    endfunction

    accum_state_e             state_q, state_d;
    logic                     acc_v_s, s2_v_s, term_ovf_s;
    logic [NT-1:0]            mac_v_s;
    logic signed [MAC_W-1:0]  mac_sum_s [NT];
    logic [ACC_BW:0]          sat_s [NT];
    logic signed [ACC_BW-1:0] acc_q [NT];
    logic signed [ACC_BW-1:0] acc_d [NT];
    logic signed [ACC_BW-1:0] res_q [NT];
    logic [CNT_BW-1:0]        cnt_q, cnt_d, res_cnt_q;
    logic                     ovf_q, ovf_d, res_ovf_q;

    assign acc_v_s = i_valid & (i_start | (state_q == ST_ACCUM));
    assign s2_v_s  = |mac_v_s;

    for (genvar k = 0; k < NT; k++) begin : g_mac
        if (k < NUM_H_TERM) begin : g_h
            indirect_pair_mac #(
                .A_BW(COE_BW), .B_BW(COE_BW), .C_BW(COE_BW), .D_BW(COE_BW), .OUT_BW(MAC_W)
            ) u_mac (
                .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_start), .i_valid(acc_v_s),
                .i_a(i_Ax[H_ROW[k]]), .i_b(i_Ax[H_COL[k]]),
                .i_c(i_Ay[H_ROW[k]]), .i_d(i_Ay[H_COL[k]]),
                .o_valid(mac_v_s[k]), .o_sum(mac_sum_s[k])
            );
        end else begin : g_b
            indirect_pair_mac #(
                .A_BW(COE_BW), .B_BW(DX_BW), .C_BW(COE_BW), .D_BW(DY_BW), .OUT_BW(MAC_W)
            ) u_mac (
                .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_start), .i_valid(acc_v_s),
                .i_a(i_Ax[k-NUM_H_TERM]), .i_b(i_diffs_x),
                .i_c(i_Ay[k-NUM_H_TERM]), .i_d(i_diffs_y),
                .o_valid(mac_v_s[k]), .o_sum(mac_sum_s[k])
            );
        end
    end

    // Next state: start wins in every state; two drain cycles cover the MAC stages.
    always_comb begin
        state_d = state_q;
        if (i_start) begin
            state_d = i_frame_end ? ST_DRAIN1 : ST_ACCUM;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ACCUM:  state_d = i_frame_end ? ST_DRAIN1 : ST_ACCUM;
                ST_DRAIN1: state_d = ST_DRAIN2;
                ST_DRAIN2: state_d = ST_DONE;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Saturating accumulate, sample counter and sticky overflow.
    always_comb begin
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        term_ovf_s = 1'b0;
        for (int k = 0; k < NT; k++) begin
            sat_s[k]   = sat_add(acc_q[k], mac_sum_s[k]);
            acc_d[k]   = acc_q[k];
            term_ovf_s = term_ovf_s | sat_s[k][ACC_BW];
        end
        if (i_start) begin
            for (int k = 0; k < NT; k++) begin
                acc_d[k] = '0;
            end
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (s2_v_s) begin
            for (int k = 0; k < NT; k++) begin
                acc_d[k] = sat_s[k][ACC_BW-1:0];
            end
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_BW'(1);
            ovf_d = ovf_q | term_ovf_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, accumulators, and result registers loaded as DONE is entered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
            for (int k = 0; k < NT; k++) begin
                acc_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < NT; k++) begin
                acc_q[k] <= acc_d[k];
            end
            if (state_d == ST_DONE) begin
                res_cnt_q <= cnt_d;
                res_ovf_q <= ovf_d;
                for (int k = 0; k < NT; k++) begin
                    res_q[k] <= acc_d[k];
                end
            end
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = (state_q == ST_DONE);
    assign o_cnt  = res_cnt_q;
    assign o_ovf  = res_ovf_q;

    for (genvar k = 0; k < NT; k++) begin : g_out
        if (k < NUM_H_TERM) begin : g_h
            assign o_H[k] = res_q[k];
        end else begin : g_b
            assign o_b[k-NUM_H_TERM] = res_q[k];
        end
    end

endmodule
